// File: rtl/crc32_sched_if.sv
// Request/response bus of the CRC scheduler: two requesters in, one result stream out.
interface crc32_sched_if;
    logic [1:0]  req_valid_i;
    logic [31:0] req_msg0_i;
    logic [31:0] req_msg1_i;
    logic [31:0] req_poly0_i;
    logic [31:0] req_poly1_i;
    logic [1:0]  req_ready_o;
    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic [31:0] rsp_crc_o;
    logic        rsp_ready_i;

    modport slave (
        input  req_valid_i, req_msg0_i, req_msg1_i, req_poly0_i, req_poly1_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_crc_o
    );

    modport master (
        output req_valid_i, req_msg0_i, req_msg1_i, req_poly0_i, req_poly1_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_crc_o
    );
endinterface

// File: rtl/crc32_sched.sv
// Two-requester round-robin scheduler that sequences an external bit-serial CRC engine
// through load, RUN_CYCLES compute steps and result capture, then holds the result.
//   state  | meaning
//   IDLE   | waiting for a request; grants one in the same cycle
//   LOAD   | engine load strobe low, operands presented
//   RUN    | engine stepping for RUN_CYCLES cycles
//   CAPT   | engine settled, result registered
//   RESP   | result valid until the consumer accepts it
module crc32_sched #(
    parameter int unsigned RUN_CYCLES = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    crc32_sched_if.slave bus,
    output logic         eng_rst_no,
    output logic         eng_compute_o,
    output logic [31:0]  eng_msg_o,
    output logic [31:0]  eng_poly_o,
    input  logic [31:0]  eng_crc_i,
    output logic         busy_o
);
    localparam int unsigned   CW       = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT, S_RESP} state_t;

    state_t      state_q;
    logic        last_q;
    logic        id_q;
    logic [31:0] msg_q;
    logic [31:0] poly_q;
    logic [31:0] crc_q;
    logic [CW-1:0] cnt_q;
    logic        rsp_valid_q;
    logic        eng_rst_n_q;
    logic        compute_q;
    logic        busy_q;

    logic        any_req;
    logic        grant_d;
    logic [1:0]  ready_d;
    logic [31:0] msg_d;
    logic [31:0] poly_d;

    assign any_req = |bus.req_valid_i;
    assign msg_d   = grant_d ? bus.req_msg1_i  : bus.req_msg0_i;
    assign poly_d  = grant_d ? bus.req_poly1_i : bus.req_poly0_i;

    // Both valid: the one not granted last wins; a lone request wins outright.
    always_comb begin
        grant_d = (&bus.req_valid_i) ? ~last_q : bus.req_valid_i[1];
        ready_d = 2'b00;
        if (rst_i && state_q == S_IDLE && any_req)
            ready_d = grant_d ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            msg_q       <= '0;
            poly_q      <= '0;
            crc_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            eng_rst_n_q <= 1'b0;
            compute_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    eng_rst_n_q <= 1'b1;
                    if (any_req) begin
                        state_q     <= S_LOAD;
                        last_q      <= grant_d;
                        id_q        <= grant_d;
                        msg_q       <= msg_d;
                        poly_q      <= poly_d;
                        eng_rst_n_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q     <= S_RUN;
                    cnt_q       <= CNT_LOAD;
                    eng_rst_n_q <= 1'b1;
                    compute_q   <= 1'b1;
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        state_q   <= S_CAPT;
                        compute_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_CAPT: begin
                    state_q     <= S_RESP;
                    crc_q       <= eng_crc_i;
                    rsp_valid_q <= 1'b1;
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = ready_d;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_id_o    = id_q;
    assign bus.rsp_crc_o   = crc_q;
    assign eng_rst_no      = eng_rst_n_q;
    assign eng_compute_o   = compute_q;
    assign eng_msg_o       = msg_q;
    assign eng_poly_o      = poly_q;
    assign busy_o          = busy_q;
endmodule

// File: doc/crc32_sched.md
CRC32_SCHED -- requirements
Module: crc32_sched

Interface
REQ-001 The block SHALL have one parameter: RUN_CYCLES, default 32, the number of compute cycles the engine needs per word.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk_i and rst_i.
REQ-003 clk_i  in  1  rising-edge clock for all state.
REQ-004 rst_i  in  1  asynchronous active-low reset.
REQ-005 req_valid_i  in  2  per-requester request valid; bit n belongs to requester n.
REQ-006 req_msg0_i, req_msg1_i  in  32 each  message word for requester 0 and requester 1.
REQ-007 req_poly0_i, req_poly1_i  in  32 each  polynomial for requester 0 and requester 1.
REQ-008 req_ready_o  out  2  one-hot accept strobe; a request transfers when valid and ready are both 1.
REQ-009 rsp_valid_o  out  1  result valid.
REQ-010 rsp_id_o  out  1  requester index of the result.
REQ-011 rsp_crc_o  out  32  CRC result.
REQ-012 rsp_ready_i  in  1  consumer accepts the result.
REQ-013 eng_rst_no  out  1  active-low load strobe to the CRC engine; the engine captures eng_msg_o and eng_poly_o while it is low.
REQ-014 eng_compute_o  out  1  engine step enable.
REQ-015 eng_msg_o, eng_poly_o  out  32 each  operands presented to the engine.
REQ-016 eng_crc_i  in  32  engine result.
REQ-017 busy_o  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, RUN, CAPT and RESP.
REQ-019 In IDLE with any req_valid_i bit set, the block SHALL grant one requester (REQ-020 to REQ-022), assert req_ready_o for that requester for exactly that cycle, latch its message, polynomial and id, and go to LOAD.
REQ-020 Arbitration SHALL be round-robin using a 1-bit last-grant register, with reset value 1 so that requester 0 wins first.
REQ-021 When both requests are valid, the requester that is not the last-granted one SHALL win.
REQ-022 When only one request is valid, that requester SHALL win regardless of the last-grant register.
REQ-023 The last-grant register SHALL update only when a grant occurs.
REQ-024 The block SHALL hold req_ready_o at 0 in every state other than IDLE, so no second request is accepted while busy.
REQ-025 LOAD SHALL last 1 cycle: eng_rst_no=0, eng_compute_o=0, eng_msg_o and eng_poly_o driven from the latched operands; next state RUN.
REQ-026 RUN SHALL last exactly RUN_CYCLES cycles with eng_compute_o=1 and eng_rst_no=1, counted by a down-counter loaded with RUN_CYCLES-1 on entry; leave RUN when the counter is 0.
REQ-027 eng_msg_o and eng_poly_o SHALL hold the latched operands in every state.
REQ-028 CAPT SHALL last 1 cycle with eng_compute_o=0, so the engine result has settled, and SHALL register eng_crc_i into rsp_crc_o; next state RESP.
REQ-029 In RESP, rsp_valid_o SHALL be 1 and rsp_crc_o and rsp_id_o SHALL be held stable until rsp_ready_i=1.
REQ-030 The RESP-to-IDLE transition SHALL occur on the cycle rsp_ready_i=1.
REQ-031 The IDLE cycle that follows RESP SHALL be able to grant a new request immediately.
REQ-032 A requester that drops req_valid_i before being granted SHALL have no effect on the block.
REQ-033 From grant to first rsp_valid_o SHALL be RUN_CYCLES+3 cycles: LOAD (1), RUN (RUN_CYCLES), CAPT (1), then RESP asserted.
REQ-034 If rsp_ready_i is already 1 on entry to RESP, the transfer SHALL complete in that single RESP cycle.
REQ-035 rsp_valid_o SHALL NOT depend combinationally on rsp_ready_i.

Reset
REQ-036 While rst_i=0, the block SHALL be in IDLE and drive: req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_crc_o=0, eng_compute_o=0, eng_rst_no=0 (engine held in reset), eng_msg_o=0, eng_poly_o=0, busy_o=0, counter=0.
REQ-037 Assertion of rst_i in any state SHALL abort the operation in flight immediately, with no response produced for the aborted request.
REQ-038 After rst_i is released, the block SHALL restart from IDLE with last-grant=1.

Verification
REQ-039 Single request: req_valid_i=01, msg=0x00000001, poly=0x04C11DB7, rsp_ready_i=1 -> rsp_valid_o 35 cycles after grant with rsp_id_o=0 and rsp_crc_o equal to the engine value for 0x00000001, checked against a bit-serial reference model.
REQ-040 Contention: req_valid_i=11 held continuously -> grants alternate 0,1,0,1 and no req_ready_o pulse appears while busy_o=1.
REQ-041 Backpressure: rsp_ready_i=0 for 10 cycles in RESP -> rsp_valid_o, rsp_crc_o and rsp_id_o stay stable, and only one response is consumed.
REQ-042 Phase check: eng_rst_no is low for exactly 1 cycle per grant, and eng_compute_o is high for exactly 32 consecutive cycles per grant.
REQ-043 Mid-RUN reset: rst_i=0 at RUN cycle 10 -> all outputs take their REQ-036 values asynchronously; after release, a request from requester 1 alone is granted and produces a correct CRC.
REQ-044 Withdrawn request: requester 1 valid for 1 cycle while the block is busy, then dropped -> requester 1 is never granted and no response carries rsp_id_o=1.
